// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic-operators library.
// Defaults here are used by the adder primitives built on top of them.
package arith_pkg;

  localparam int CNT_W_DEFAULT = 16;

endpackage : arith_pkg

// File: rtl/meio_somador_lane.sv
// One combinational 1-bit half-adder lane.
// The sum is the XOR of the operands and the carry is their AND.
module meio_somador_lane (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule : meio_somador_lane

// File: rtl/meio_somador.sv
// Registered WIDTH-lane half adder with a valid flag and a saturating count of
// accepted cycles in which any lane produced a carry.
module meio_somador
  import arith_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  output logic [CNT_W-1:0] carry_count
);

  logic [WIDTH-1:0] s_comb;
  logic [WIDTH-1:0] c_comb;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    meio_somador_lane u_lane (
      .a_i (A[gi]),
      .b_i (B[gi]),
      .s_o (s_comb[gi]),
      .c_o (c_comb[gi])
    );
  end

  // Operands only reach the registers when qualified, so junk on A/B is ignored.
  always_comb begin
    s_d     = s_q;
    c_d     = c_q;
    valid_d = in_valid;
    cnt_d   = cnt_q;
    if (in_valid) begin
      s_d = s_comb;
      c_d = c_comb;
      if ((|c_comb) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s_q     <= s_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign S           = s_q;
  assign C           = c_q;
  assign out_valid   = valid_q;
  assign carry_count = cnt_q;

endmodule : meio_somador

// File: tb/tb_meio_somador.sv
// Bench for meio_somador: three instances (1 lane, 4 lanes, 1 lane with a 2-bit
// counter) share control inputs and are compared with an arithmetic reference model.
module tb_meio_somador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;

  logic        ov1, s1, c1;
  logic [15:0] cnt1;
  logic        ov4;
  logic [3:0]  s4, c4;
  logic [15:0] cnt4;
  logic        ovs, ss, cs;
  logic [1:0]  cnts;

  int total = 0;
  int bad   = 0;

  // reference state
  int  exp_v;
  int  exp_s1, exp_c1, exp_cnt1;
  int  exp_s4, exp_c4, exp_cnt4;
  int  exp_cnts;

  always #5 clk = ~clk;

  meio_somador #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a1), .B(b1),
    .out_valid(ov1), .S(s1), .C(c1), .carry_count(cnt1)
  );

  meio_somador #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a4), .B(b4),
    .out_valid(ov4), .S(s4), .C(c4), .carry_count(cnt4)
  );

  meio_somador #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a1), .B(b1),
    .out_valid(ovs), .S(ss), .C(cs), .carry_count(cnts)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lane results from ordinary arithmetic: a+b gives sum = total mod 2, carry = total div 2.
  task automatic model_edge(input logic r, input logic v, input logic a1_v, input logic b1_v,
                            input logic [3:0] a4_v, input logic [3:0] b4_v);
    int t;
    if (r) begin
      exp_v = 0;
      exp_s1 = 0; exp_c1 = 0; exp_cnt1 = 0;
      exp_s4 = 0; exp_c4 = 0; exp_cnt4 = 0;
      exp_cnts = 0;
    end else if (v) begin
      exp_v = 1;
      t = int'(a1_v) + int'(b1_v);
      exp_s1 = t % 2;
      exp_c1 = t / 2;
      exp_s4 = 0;
      exp_c4 = 0;
      for (int i = 0; i < 4; i++) begin
        t = int'(a4_v[i]) + int'(b4_v[i]);
        exp_s4 += (t % 2) * (2 ** i);
        exp_c4 += (t / 2) * (2 ** i);
      end
      if (exp_c1 != 0) begin
        exp_cnt1 = (exp_cnt1 + 1 > 65535) ? 65535 : exp_cnt1 + 1;
        exp_cnts = (exp_cnts + 1 > 3) ? 3 : exp_cnts + 1;
      end
      if (exp_c4 != 0) exp_cnt4 = (exp_cnt4 + 1 > 65535) ? 65535 : exp_cnt4 + 1;
    end else begin
      exp_v = 0;
    end
  endtask

  task automatic check_all(input string ph);
    check_eq({ph, ".w1.valid"}, 32'(ov1), 32'(exp_v));
    check_eq({ph, ".w1.S"},     32'(s1),  32'(exp_s1));
    check_eq({ph, ".w1.C"},     32'(c1),  32'(exp_c1));
    check_eq({ph, ".w1.cnt"},   32'(cnt1), 32'(exp_cnt1));
    check_eq({ph, ".w4.valid"}, 32'(ov4), 32'(exp_v));
    check_eq({ph, ".w4.S"},     32'(s4),  32'(exp_s4));
    check_eq({ph, ".w4.C"},     32'(c4),  32'(exp_c4));
    check_eq({ph, ".w4.cnt"},   32'(cnt4), 32'(exp_cnt4));
    check_eq({ph, ".sat.valid"}, 32'(ovs), 32'(exp_v));
    check_eq({ph, ".sat.S"},     32'(ss),  32'(exp_s1));
    check_eq({ph, ".sat.C"},     32'(cs),  32'(exp_c1));
    check_eq({ph, ".sat.cnt"},   32'(cnts), 32'(exp_cnts));
  endtask

  task automatic step(input string ph, input logic r, input logic v,
                      input logic a1_v, input logic b1_v,
                      input logic [3:0] a4_v, input logic [3:0] b4_v);
    rst = r; in_valid = v;
    a1 = a1_v; b1 = b1_v; a4 = a4_v; b4 = b4_v;
    @(posedge clk);
    model_edge(r, v, a1_v, b1_v, a4_v, b4_v);
    #1;
    $display("txn %s rst=%0b v=%0b a1=%b b1=%b a4=%b b4=%b -> w1 S=%b C=%b cnt=%0d | w4 S=%b C=%b cnt=%0d | sat cnt=%0d",
             ph, r, v, a1_v, b1_v, a4_v, b4_v, s1, c1, cnt1, s4, c4, cnt4, cnts);
    check_all(ph);
  endtask

  initial begin
    logic r, v, ra, rb;
    logic [3:0] ra4, rb4;
    exp_v = 0;
    exp_s1 = 0; exp_c1 = 0; exp_cnt1 = 0;
    exp_s4 = 0; exp_c4 = 0; exp_cnt4 = 0; exp_cnts = 0;

    // reset dominates a valid carry-producing input
    step("reset", 1, 1, 1, 1, 4'hF, 4'hF);
    step("reset", 1, 1, 1, 1, 4'hF, 4'hF);

    // full truth table on consecutive cycles
    step("tt00", 0, 1, 0, 0, 4'b0000, 4'b0000);
    step("tt01", 0, 1, 0, 1, 4'b0000, 4'b1111);
    step("tt10", 0, 1, 1, 0, 4'b1111, 4'b0000);
    step("tt11", 0, 1, 1, 1, 4'b1100, 4'b1010);
    check_eq("tt.cnt_after_seq", 32'(cnt1), 32'd1);
    check_eq("tt.lane4_S", 32'(s4), 32'h6);
    check_eq("tt.lane4_C", 32'(c4), 32'h8);

    // hold: one valid (1,0) then idle cycles with carrying operands and with X operands
    step("hold_ld", 0, 1, 1, 0, 4'b0101, 4'b0011);
    step("hold",    0, 0, 1, 1, 4'hF, 4'hF);
    step("hold",    0, 0, 1, 1, 4'hF, 4'hF);
    step("hold_x",  0, 0, 1'bx, 1'bx, 4'bxxxx, 4'bxxxx);

    // saturation of the 2-bit counter
    step("sat_rst", 1, 0, 0, 0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) step("sat", 0, 1, 1, 1, 4'h1, 4'h1);
    check_eq("sat.stays3", 32'(cnts), 32'd3);

    // reset mid-stream discards the pending result
    step("mid_v",   0, 1, 1, 1, 4'hF, 4'hF);
    step("mid_rst", 1, 1, 1, 1, 4'hF, 4'hF);

    // randomized traffic with sporadic resets and X on idle operands
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 3) != 0);
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ra4 = 4'($urandom_range(0, 15));
      rb4 = 4'($urandom_range(0, 15));
      if (!v && !r && $urandom_range(0, 1) == 1) begin
        ra = 1'bx; rb = 1'bx; ra4 = 4'bxxxx; rb4 = 4'bxxxx;
      end
      step("rand", r, v, ra, rb, ra4, rb4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_meio_somador
